// File: rtl/test_monitor_pkg.sv
// Shared types and arithmetic helpers for the test monitor.
// Counters use sat_add so that a long run never wraps back to a small value.
package test_pkg;

  localparam int unsigned MAX_CHANNELS = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4
  } mon_state_t;

  // Adds a and b and clamps the result to the largest w-bit value (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

  function automatic logic [4:0] popcount(input logic [MAX_CHANNELS-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_CHANNELS; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/test_monitor_compare.sv
// Combinational masked compare across all channels: mismatch vector,
// number of failing channels and the lowest failing channel index.
module mon_compare
  import test_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int IDX_W    = 2
) (
  input  logic [CHANNELS-1:0]       valid,
  input  logic [CHANNELS*WIDTH-1:0] exp_words,
  input  logic [CHANNELS*WIDTH-1:0] act_words,
  input  logic [CHANNELS*WIDTH-1:0] mask_words,
  output logic [CHANNELS-1:0]       mismatch,
  output logic [4:0]                mismatch_count,
  output logic [IDX_W-1:0]          lowest_idx
);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign mismatch[gi] = valid[gi] &&
          (((exp_words[gi*WIDTH +: WIDTH] ^ act_words[gi*WIDTH +: WIDTH]) &
            mask_words[gi*WIDTH +: WIDTH]) != '0);
    end
  endgenerate

  assign mismatch_count = popcount(MAX_CHANNELS'(mismatch));

  // Scan from the top so the lowest set index is the one left standing.
  always_comb begin
    lowest_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mismatch[i]) begin
        lowest_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/test_monitor.sv
// Test monitor: run/verdict FSM with saturating cycle and failure counters
// and a one-shot capture of where and when the first mismatch happened.
module test_monitor
  import test_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 32,
  parameter int MAX_CYCLES = 32,
  parameter int CNT_W      = 16,
  localparam int IDX_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      end_req,
  input  logic [CHANNELS-1:0]       chk_valid,
  input  logic [CHANNELS*WIDTH-1:0] chk_expect,
  input  logic [CHANNELS*WIDTH-1:0] chk_actual,
  input  logic [CHANNELS*WIDTH-1:0] chk_mask,
  output mon_state_t                state,
  output logic                      done,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [CNT_W-1:0]          fail_count,
  output logic [CHANNELS-1:0]       fail_vec,
  output logic [IDX_W-1:0]          first_fail_chan,
  output logic [CNT_W-1:0]          first_fail_cycle
);

  // Compared at 32 bits so a narrow counter never aliases onto the limit.
  localparam logic [31:0] LAST_CYCLE = 32'(MAX_CYCLES - 1);

  mon_state_t          state_reg, state_next;
  logic                done_reg;
  logic [CNT_W-1:0]    cycle_count_reg;
  logic [CNT_W-1:0]    fail_count_reg;
  logic [CHANNELS-1:0] fail_vec_reg;
  logic [IDX_W-1:0]    first_fail_chan_reg;
  logic [CNT_W-1:0]    first_fail_cycle_reg;

  logic [CHANNELS-1:0] mismatch;
  logic [4:0]          mismatch_count;
  logic [IDX_W-1:0]    lowest_idx;
  logic                any_mismatch;
  logic                timeout_hit;
  logic                clear_all;

  mon_compare #(
    .CHANNELS(CHANNELS),
    .WIDTH   (WIDTH),
    .IDX_W   (IDX_W)
  ) u_compare (
    .valid         (chk_valid),
    .exp_words     (chk_expect),
    .act_words     (chk_actual),
    .mask_words    (chk_mask),
    .mismatch      (mismatch),
    .mismatch_count(mismatch_count),
    .lowest_idx    (lowest_idx)
  );

  assign any_mismatch = |mismatch;
  assign timeout_hit  = (32'(cycle_count_reg) == LAST_CYCLE);
  assign clear_all    = start && (state_reg != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        // end_req outranks the timeout when both land on the same edge.
        if (end_req) begin
          state_next = ((fail_vec_reg != '0) || any_mismatch) ? FAIL : PASS;
        end else if (timeout_hit) begin
          state_next = TIMEOUT;
        end
      end
      PASS, FAIL, TIMEOUT: begin
        if (start) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_reg             <= 1'b0;
      cycle_count_reg      <= '0;
      fail_count_reg       <= '0;
      fail_vec_reg         <= '0;
      first_fail_chan_reg  <= '0;
      first_fail_cycle_reg <= '0;
    end else begin
      done_reg <= (state_next == PASS) || (state_next == FAIL) ||
                  (state_next == TIMEOUT);
      if (state_reg == RUN) begin
        cycle_count_reg <= CNT_W'(sat_add(32'(cycle_count_reg), 32'd1, CNT_W));
        fail_count_reg  <= CNT_W'(sat_add(32'(fail_count_reg),
                                          32'(mismatch_count), CNT_W));
        fail_vec_reg    <= fail_vec_reg | mismatch;
        // An empty fail_vec means no mismatch has been captured yet.
        if ((fail_vec_reg == '0) && any_mismatch) begin
          first_fail_chan_reg  <= lowest_idx;
          first_fail_cycle_reg <= cycle_count_reg;
        end
      end else if (clear_all) begin
        cycle_count_reg      <= '0;
        fail_count_reg       <= '0;
        fail_vec_reg         <= '0;
        first_fail_chan_reg  <= '0;
        first_fail_cycle_reg <= '0;
      end
    end
  end

  assign state            = state_reg;
  assign done             = done_reg;
  assign cycle_count      = cycle_count_reg;
  assign fail_count       = fail_count_reg;
  assign fail_vec         = fail_vec_reg;
  assign first_fail_chan  = first_fail_chan_reg;
  assign first_fail_cycle = first_fail_cycle_reg;

endmodule

// File: tb/tb_test_monitor.sv
// Directed bench for test_monitor: a default instance plus a 4-bit-counter
// instance for saturation, both on the same clock and compare inputs.
module tb_test_monitor;
  import test_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         start, end_req;
  logic         start_s, end_s;
  logic [3:0]   chk_valid;
  logic [127:0] chk_expect, chk_actual, chk_mask;

  mon_state_t   state;
  logic         done;
  logic [15:0]  cycle_count, fail_count, first_fail_cycle;
  logic [3:0]   fail_vec;
  logic [1:0]   first_fail_chan;

  mon_state_t   state_s;
  logic         done_s;
  logic [3:0]   cycle_count_s, fail_count_s, first_fail_cycle_s;
  logic [3:0]   fail_vec_s;
  logic [1:0]   first_fail_chan_s;

  int checks = 0;
  int errors = 0;

  test_monitor u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .end_req(end_req),
    .chk_valid(chk_valid), .chk_expect(chk_expect), .chk_actual(chk_actual),
    .chk_mask(chk_mask), .state(state), .done(done),
    .cycle_count(cycle_count), .fail_count(fail_count), .fail_vec(fail_vec),
    .first_fail_chan(first_fail_chan), .first_fail_cycle(first_fail_cycle)
  );

  test_monitor #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .end_req(end_s),
    .chk_valid(chk_valid), .chk_expect(chk_expect), .chk_actual(chk_actual),
    .chk_mask(chk_mask), .state(state_s), .done(done_s),
    .cycle_count(cycle_count_s), .fail_count(fail_count_s),
    .fail_vec(fail_vec_s), .first_fail_chan(first_fail_chan_s),
    .first_fail_cycle(first_fail_cycle_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_chk();
    chk_valid  = 4'h0;
    chk_expect = {4{32'hA5A5_0F0F}};
    chk_actual = chk_expect;
    chk_mask   = {128{1'b1}};
  endtask

  task automatic match_chk();
    clear_chk();
    chk_valid = 4'hF;
  endtask

  // Flip bit 8 of the actual word on every selected channel.
  task automatic mism(input logic [3:0] chans);
    match_chk();
    for (int i = 0; i < 4; i++) begin
      if (chans[i]) chk_actual[i*32 +: 32] = chk_actual[i*32 +: 32] ^ 32'h0000_0100;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; end_req = 1'b0; start_s = 1'b0; end_s = 1'b0;
    clear_chk();
    tick(); tick();
    check("rst_state", 64'(state), 64'(IDLE));
    check("rst_done", 64'(done), 64'd0);
    check("rst_cycle", 64'(cycle_count), 64'd0);
    check("rst_fail", 64'(fail_count), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_hold", 64'(state), 64'(IDLE));

    // Clean run: 10 matching cycles then end_req.
    start = 1'b1; tick(); start = 1'b0;
    check("run_enter", 64'(state), 64'(RUN));
    check("run_cycle0", 64'(cycle_count), 64'd0);
    match_chk();
    repeat (10) tick();
    check("clean_cycle10", 64'(cycle_count), 64'd10);
    end_req = 1'b1; tick(); end_req = 1'b0;
    check("clean_state", 64'(state), 64'(PASS));
    check("clean_done", 64'(done), 64'd1);
    check("clean_fail", 64'(fail_count), 64'd0);
    check("clean_vec", 64'(fail_vec), 64'd0);
    check("clean_cycle", 64'(cycle_count), 64'd11);

    // Mismatch on channels 1 and 3 at cycle 5, end_req at cycle 8.
    start = 1'b1; tick(); start = 1'b0;
    check("mm_restart_cycle", 64'(cycle_count), 64'd0);
    match_chk();
    repeat (5) tick();
    mism(4'b1010); tick();
    check("mm_fail_now", 64'(fail_count), 64'd2);
    match_chk();
    repeat (2) tick();
    check("mm_cycle8", 64'(cycle_count), 64'd8);
    end_req = 1'b1; tick(); end_req = 1'b0;
    check("mm_state", 64'(state), 64'(FAIL));
    check("mm_fail", 64'(fail_count), 64'd2);
    check("mm_vec", 64'(fail_vec), 64'b1010);
    check("mm_ffchan", 64'(first_fail_chan), 64'd1);
    check("mm_ffcycle", 64'(first_fail_cycle), 64'd5);
    check("mm_cycle", 64'(cycle_count), 64'd9);
    tick();
    check("mm_frozen", 64'(cycle_count), 64'd9);

    // Restart from FAIL, then masked-off and invalid differences.
    start = 1'b1; tick(); start = 1'b0;
    check("rs_state", 64'(state), 64'(RUN));
    check("rs_fail", 64'(fail_count), 64'd0);
    check("rs_vec", 64'(fail_vec), 64'd0);
    check("rs_ffcycle", 64'(first_fail_cycle), 64'd0);
    check("rs_ffchan", 64'(first_fail_chan), 64'd0);
    match_chk();
    chk_mask   = {4{32'h0000_FFFF}};
    chk_actual = chk_expect ^ {4{32'hFFFF_0000}};
    tick();
    clear_chk();
    chk_actual = ~chk_expect;
    tick();
    match_chk();
    chk_mask   = '0;
    chk_actual = ~chk_expect;
    tick();
    check("filt_fail", 64'(fail_count), 64'd0);
    match_chk();
    end_req = 1'b1; tick(); end_req = 1'b0;
    check("filt_state", 64'(state), 64'(PASS));

    // Timeout with a mismatch on the timeout cycle.
    start = 1'b1; tick(); start = 1'b0;
    clear_chk();
    repeat (31) tick();
    check("to_pre_state", 64'(state), 64'(RUN));
    check("to_pre_cycle", 64'(cycle_count), 64'd31);
    mism(4'b0001); tick();
    check("to_state", 64'(state), 64'(TIMEOUT));
    check("to_cycle", 64'(cycle_count), 64'd32);
    check("to_fail", 64'(fail_count), 64'd1);
    check("to_done", 64'(done), 64'd1);
    clear_chk();
    end_req = 1'b1; tick(); end_req = 1'b0;
    check("to_endreq_ign", 64'(state), 64'(TIMEOUT));

    // end_req on the timeout cycle wins.
    start = 1'b1; tick(); start = 1'b0;
    repeat (31) tick();
    end_req = 1'b1; tick(); end_req = 1'b0;
    check("tw_state", 64'(state), 64'(PASS));
    check("tw_cycle", 64'(cycle_count), 64'd32);

    // start ignored in RUN; same-cycle mismatch with end_req -> FAIL.
    start = 1'b1; tick(); start = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    check("run_start_ign", 64'(cycle_count), 64'd2);
    mism(4'b0100);
    end_req = 1'b1; tick(); end_req = 1'b0;
    clear_chk();
    check("same_state", 64'(state), 64'(FAIL));
    check("same_ffchan", 64'(first_fail_chan), 64'd2);
    check("same_ffcycle", 64'(first_fail_cycle), 64'd2);
    check("same_vec", 64'(fail_vec), 64'b0100);

    // Asynchronous reset mid-RUN.
    start = 1'b1; tick(); start = 1'b0;
    mism(4'b0111); tick();
    clear_chk();
    check("ar_fail3", 64'(fail_count), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_state", 64'(state), 64'(IDLE));
    check("ar_fail", 64'(fail_count), 64'd0);
    check("ar_cycle", 64'(cycle_count), 64'd0);
    check("ar_vec", 64'(fail_vec), 64'd0);
    check("ar_done", 64'(done), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_idle", 64'(state), 64'(IDLE));

    // Saturation on the 4-bit-counter instance.
    start_s = 1'b1; tick(); start_s = 1'b0;
    mism(4'b0001);
    repeat (20) tick();
    check("sat_fail", 64'(fail_count_s), 64'd15);
    check("sat_cycle", 64'(cycle_count_s), 64'd15);
    check("sat_state_run", 64'(state_s), 64'(RUN));
    clear_chk();
    end_s = 1'b1; tick(); end_s = 1'b0;
    check("sat_state", 64'(state_s), 64'(FAIL));
    check("sat_main_idle", 64'(state), 64'(IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
